bp_trace_decoder: RTL and testbench
===================================

Name: bp_trace_decoder

Overview:
- Receive end of the Nexus-style trace link.
- Consumes `nexus_trace_pkt_s` packets (`src_id`, `mcode`, `addr`) from the trace FIFO using valid/ready.
- Classifies each packet, tracks a sync anchor (last full-branch target), and filters out malformed or unanchored packets.
- Emits decoded branch events to the trace-analysis/replay logic through a 2-entry output buffer, and keeps saturating statistics counters.

Parameters:
- `SRC_ID`, `2'b00`: source ID accepted. Packets with any other `src_id` are consumed and dropped.
- `OUT_DEPTH`, `2`: output buffer entries. Fixed at 2; other values are unsupported.
- `CNT_W`, `16`: width of each statistics counter.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `trace_pkt_i`  in  `$bits(nexus_trace_pkt_s)`  incoming packet.
- `trace_v_i`  in  1  packet valid.
- `trace_ready_o`  out  1  decoder can accept a packet. Transfer occurs when `trace_v_i & trace_ready_o`.
- `evt_v_o`  out  1  decoded event valid.
- `evt_ready_i`  in  1  consumer accepts the event. Pop occurs when `evt_v_o & evt_ready_i`.
- `evt_kind_o`  out  1  0 = full branch (`addr` is absolute target); 1 = compressed (`addr` is byte offset).
- `evt_addr_o`  out  32  absolute target PC or offset, per `evt_kind_o`.
- `evt_anchor_o`  out  32  anchor PC in effect when the event was decoded.
- `synced_o`  out  1  FSM is in `SYNC`.
- `full_cnt_o`, `comp_cnt_o`, `drop_cnt_o`, `err_cnt_o`  out  `CNT_W` each  statistics counters.

Behaviour:
- Reset (synchronous, `reset_i` high at a clock edge):
  - Output buffer emptied; `evt_v_o=0`.
  - FSM to `UNSYNC`; anchor=0.
  - All counters=0.
  - `trace_ready_o=1` from the first cycle after reset deasserts.
  - Reset asserted mid-transfer discards any in-flight packet and all buffered events; nothing is emitted for them.
- Input handshake:
  - `trace_ready_o` is a registered function of buffer occupancy: 1 when occupancy<2, else 0.
  - It does not combinationally depend on `evt_ready_i`.
- Latency: a packet accepted at edge t produces its event at the buffer head with `evt_v_o=1` after edge t, if the buffer was empty. Otherwise the event queues in FIFO order.
- Classification of an accepted packet, evaluated in this priority order:
  1. `src_id != SRC_ID`: drop; `drop_cnt++`.
  2. `mcode == NEXUS_MCODE_DIRECT_BRANCH`:
     - Emit kind=0, addr=`pkt.addr`, anchor=`pkt.addr`.
     - anchor<=`pkt.addr`; FSM->`SYNC`; `full_cnt++`.
  3. `mcode == NEXUS_MCODE_COMPRESSED`, protocol violation: `addr[31:8]!=0`, `addr==0`, or `addr==4` (none of these is ever produced by the encoder).
     - Drop; `err_cnt++`.
     - FSM unchanged.
  4. `mcode == NEXUS_MCODE_COMPRESSED` while `UNSYNC`: drop; `drop_cnt++`. No anchor exists.
  5. `mcode == NEXUS_MCODE_COMPRESSED` while `SYNC`:
     - Emit kind=1, addr=`{24'b0, addr[7:0]}`, anchor=current anchor.
     - Anchor unchanged; `comp_cnt++`.
  6. Any other `mcode`:
     - Drop; `err_cnt++`.
     - FSM->`UNSYNC`; anchor cleared to 0. Resync is required after an unknown packet.
- FSM:
  - States: `UNSYNC`, `SYNC`.
  - `UNSYNC->SYNC` on an accepted full branch.
  - `SYNC->UNSYNC` only on an unknown `mcode` or reset.
  - A full branch in `SYNC` stays in `SYNC` and updates the anchor.
- Output buffer:
  - 2-entry FIFO holding `{kind, addr, anchor}`.
  - Push and pop in the same cycle are both allowed at any occupancy. At occupancy 2, `trace_ready_o=0`, so no push can occur.
  - Occupancy is unchanged on a simultaneous push and pop.
  - Head outputs are stable while `evt_v_o=1` and `evt_ready_i=0`.
- Counters:
  - Each counter saturates at all-ones and never wraps.
  - At most one counter increments per accepted packet.
  - Dropped and error packets consume no buffer slot, but are still accepted only when `trace_ready_o=1`.
- `synced_o` equals the registered FSM state.

Test Plan:
- Sync and emit:
  - Stimulus: after reset, send DIRECT_BRANCH addr=`0x8000_0100`, then COMPRESSED addr=`0x40`, with `evt_ready_i=1`.
  - Required: events (0, `0x8000_0100`, anchor `0x8000_0100`) then (1, `0x40`, anchor `0x8000_0100`), each one cycle after acceptance; `full_cnt=1`, `comp_cnt=1`, `synced_o=1`.
- Unanchored drop:
  - Stimulus: after reset, send COMPRESSED addr=`0x10`.
  - Required: no event; `drop_cnt=1`; `synced_o=0`.
- Backpressure:
  - Stimulus: hold `evt_ready_i=0` and send 3 valid full branches back-to-back.
  - Required: `trace_ready_o` falls after the 2nd acceptance; the 3rd is held. Releasing `evt_ready_i` yields all 3 events in order with no loss or duplication.
- Protocol errors:
  - Stimulus: in `SYNC`, send COMPRESSED addr=`0x104`, then COMPRESSED addr=`0x4`, then an unknown `mcode`.
  - Required: `err_cnt=3`, no events, `synced_o=0` after the third packet. A subsequent COMPRESSED addr=`0x20` increments `drop_cnt`.
- Source filter and saturation:
  - Stimulus: `src_id=2'b01` packets, `CNT_W=4`, 20 packets.
  - Required: no events; `drop_cnt` stops at 15.
- Mid-operation reset:
  - Stimulus: with 2 buffered events and `evt_ready_i=0`, pulse `reset_i` for 1 cycle.
  - Required: next cycle `evt_v_o=0`, counters 0, `synced_o=0`, `trace_ready_o=1`.

Source files
------------

// File: rtl/bp_trace_decoder.sv
// Nexus-style trace link receive-side decoder: classifies packets, tracks a sync anchor, emits branch events.
// Latency: an event is visible at the output head one cycle after its packet is accepted (buffer empty).
// Backpressure: 2-entry output buffer; trace_ready_o is registered and drops when the buffer is full.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   trace_pkt_i/_v_i        incoming packet, valid; trace_ready_o = accept
//   evt_v_o/evt_ready_i     decoded event handshake
//   evt_kind_o/_addr_o      0 = full branch (absolute target), 1 = compressed (byte offset)
//   evt_anchor_o            anchor PC in effect when the event was decoded
//   synced_o                FSM is in SYNC
//   *_cnt_o                 saturating statistics counters

package bp_trace_pkg;

  localparam logic [5:0] NEXUS_MCODE_DIRECT_BRANCH = 6'h03;
  localparam logic [5:0] NEXUS_MCODE_COMPRESSED    = 6'h04;

  typedef struct packed {
    logic [1:0]  src_id;
    logic [5:0]  mcode;
    logic [31:0] addr;
  } nexus_trace_pkt_s;

  typedef struct packed {
    logic        kind;
    logic [31:0] addr;
    logic [31:0] anchor;
  } trace_evt_s;

endpackage

module bp_trace_decoder
  import bp_trace_pkg::*;
#(
  parameter logic [1:0] SRC_ID    = 2'b00,
  parameter int         OUT_DEPTH = 2,
  parameter int         CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  nexus_trace_pkt_s trace_pkt_i,
  input  logic             trace_v_i,
  output logic             trace_ready_o,
  output logic             evt_v_o,
  input  logic             evt_ready_i,
  output logic             evt_kind_o,
  output logic [31:0]      evt_addr_o,
  output logic [31:0]      evt_anchor_o,
  output logic             synced_o,
  output logic [CNT_W-1:0] full_cnt_o,
  output logic [CNT_W-1:0] comp_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef enum logic {UNSYNC = 1'b0, SYNC = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [31:0]      anchor_q, anchor_d;
  logic [1:0]       occ_q, occ_d;
  logic             ready_q;
  logic             wr_ptr_q, rd_ptr_q;
  trace_evt_s       buf_q [2];
  logic [CNT_W-1:0] full_cnt_q, comp_cnt_q, drop_cnt_q, err_cnt_q;

  logic       accept, push, pop;
  trace_evt_s evt_d;
  logic       inc_full, inc_comp, inc_drop, inc_err;
  logic       comp_bad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  assign accept = trace_v_i & ready_q;
  assign pop    = (occ_q != 2'd0) & evt_ready_i;

  // Compressed offsets the encoder never produces: wider than a byte, zero, or one instruction.
  assign comp_bad = (trace_pkt_i.addr[31:8] != 24'd0) ||
                    (trace_pkt_i.addr == 32'd0) ||
                    (trace_pkt_i.addr == 32'd4);

  // Classification, next FSM state and anchor.
  always_comb begin
    state_d  = state_q;
    anchor_d = anchor_q;
    push     = 1'b0;
    evt_d    = '0;
    inc_full = 1'b0;
    inc_comp = 1'b0;
    inc_drop = 1'b0;
    inc_err  = 1'b0;
    if (accept) begin
      if (trace_pkt_i.src_id != SRC_ID) begin
        inc_drop = 1'b1;
      end else if (trace_pkt_i.mcode == NEXUS_MCODE_DIRECT_BRANCH) begin
        push     = 1'b1;
        evt_d    = '{kind: 1'b0, addr: trace_pkt_i.addr, anchor: trace_pkt_i.addr};
        anchor_d = trace_pkt_i.addr;
        state_d  = SYNC;
        inc_full = 1'b1;
      end else if (trace_pkt_i.mcode == NEXUS_MCODE_COMPRESSED) begin
        if (comp_bad) begin
          inc_err = 1'b1;
        end else if (state_q == UNSYNC) begin
          inc_drop = 1'b1;
        end else begin
          push     = 1'b1;
          evt_d    = '{kind: 1'b1, addr: {24'd0, trace_pkt_i.addr[7:0]}, anchor: anchor_q};
          inc_comp = 1'b1;
        end
      end else begin
        // Unknown message: the anchor can no longer be trusted.
        inc_err  = 1'b1;
        state_d  = UNSYNC;
        anchor_d = 32'd0;
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= UNSYNC;
      anchor_q   <= 32'd0;
      occ_q      <= 2'd0;
      ready_q    <= 1'b1;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      full_cnt_q <= '0;
      comp_cnt_q <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      anchor_q   <= anchor_d;
      occ_q      <= occ_d;
      ready_q    <= (occ_d < 2'(OUT_DEPTH));
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      full_cnt_q <= sat_inc(full_cnt_q, inc_full);
      comp_cnt_q <= sat_inc(comp_cnt_q, inc_comp);
      drop_cnt_q <= sat_inc(drop_cnt_q, inc_drop);
      err_cnt_q  <= sat_inc(err_cnt_q, inc_err);
    end
  end

  // Payload storage needs no reset; occupancy qualifies it.
  always_ff @(posedge clk_i) begin
    if (push) buf_q[wr_ptr_q] <= evt_d;
  end

  assign trace_ready_o = ready_q;
  assign evt_v_o       = (occ_q != 2'd0);
  assign evt_kind_o    = buf_q[rd_ptr_q].kind;
  assign evt_addr_o    = buf_q[rd_ptr_q].addr;
  assign evt_anchor_o  = buf_q[rd_ptr_q].anchor;
  assign synced_o      = (state_q == SYNC);
  assign full_cnt_o    = full_cnt_q;
  assign comp_cnt_o    = comp_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_bp_trace_decoder.sv
module tb_bp_trace_decoder;
  import bp_trace_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  nexus_trace_pkt_s trace_pkt = '0;
  logic             trace_v = 1'b0;
  logic             trace_ready;
  logic             evt_v;
  logic             evt_ready = 1'b0;
  logic             evt_kind;
  logic [31:0]      evt_addr;
  logic [31:0]      evt_anchor;
  logic             synced;
  logic [CNT_W-1:0] full_cnt, comp_cnt, drop_cnt, err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_trace_decoder #(.SRC_ID(2'b00), .OUT_DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_i(reset),
    .trace_pkt_i(trace_pkt), .trace_v_i(trace_v), .trace_ready_o(trace_ready),
    .evt_v_o(evt_v), .evt_ready_i(evt_ready),
    .evt_kind_o(evt_kind), .evt_addr_o(evt_addr), .evt_anchor_o(evt_anchor),
    .synced_o(synced),
    .full_cnt_o(full_cnt), .comp_cnt_o(comp_cnt), .drop_cnt_o(drop_cnt), .err_cnt_o(err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one packet and hold it until accepted (bounded).
  task automatic send(input logic [1:0] src, input logic [5:0] mc, input logic [31:0] a);
    logic done;
    done = 1'b0;
    trace_pkt = '{src_id: src, mcode: mc, addr: a};
    trace_v   = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      if (trace_ready) done = 1'b1;
      tick();
    end
    trace_v = 1'b0;
    chk("send_accepted", {63'd0, done}, 64'd1);
  endtask

  task automatic chk_event(input string tag, input logic k, input logic [31:0] a, input logic [31:0] anc);
    chk(tag, {evt_v, evt_kind, evt_addr, evt_anchor}, {1'b1, k, a, anc});
  endtask

  logic [64:0] got [$];
  logic [31:0] bp_addr [3];

  initial begin
    // Reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_evt_v", {63'd0, evt_v}, 64'd0);
    chk("rst_ready", {63'd0, trace_ready}, 64'd1);
    chk("rst_synced", {63'd0, synced}, 64'd0);
    chk("rst_cnts", {48'd0, full_cnt, comp_cnt, drop_cnt, err_cnt}, 64'd0);

    // Unanchored compressed packet is dropped
    send(2'b00, NEXUS_MCODE_COMPRESSED, 32'h10);
    chk("unanch_evt_v", {63'd0, evt_v}, 64'd0);
    chk("unanch_drop", {60'd0, drop_cnt}, 64'd1);
    chk("unanch_synced", {63'd0, synced}, 64'd0);

    // Sync and emit
    evt_ready = 1'b1;
    send(2'b00, NEXUS_MCODE_DIRECT_BRANCH, 32'h8000_0100);
    chk_event("sync_full_evt", 1'b0, 32'h8000_0100, 32'h8000_0100);
    chk("sync_synced", {63'd0, synced}, 64'd1);
    send(2'b00, NEXUS_MCODE_COMPRESSED, 32'h40);
    chk_event("sync_comp_evt", 1'b1, 32'h40, 32'h8000_0100);
    tick();
    chk("sync_drained", {63'd0, evt_v}, 64'd0);
    chk("sync_full_cnt", {60'd0, full_cnt}, 64'd1);
    chk("sync_comp_cnt", {60'd0, comp_cnt}, 64'd1);

    // Protocol errors while synced
    send(2'b00, NEXUS_MCODE_COMPRESSED, 32'h104);
    chk("err1_evt_v", {63'd0, evt_v}, 64'd0);
    send(2'b00, NEXUS_MCODE_COMPRESSED, 32'h4);
    chk("err2_evt_v", {63'd0, evt_v}, 64'd0);
    chk("err2_synced", {63'd0, synced}, 64'd1);
    send(2'b00, 6'h3F, 32'h1234);
    chk("err3_evt_v", {63'd0, evt_v}, 64'd0);
    chk("err3_synced", {63'd0, synced}, 64'd0);
    chk("err_cnt", {60'd0, err_cnt}, 64'd3);
    send(2'b00, NEXUS_MCODE_COMPRESSED, 32'h20);
    chk("err_after_drop", {60'd0, drop_cnt}, 64'd2);
    chk("err_after_evt_v", {63'd0, evt_v}, 64'd0);

    // Backpressure: three full branches with the consumer stalled
    bp_addr[0] = 32'h0000_1000;
    bp_addr[1] = 32'h0000_2000;
    bp_addr[2] = 32'h0000_3000;
    evt_ready = 1'b0;
    send(2'b00, NEXUS_MCODE_DIRECT_BRANCH, bp_addr[0]);
    chk("bp_ready_after1", {63'd0, trace_ready}, 64'd1);
    send(2'b00, NEXUS_MCODE_DIRECT_BRANCH, bp_addr[1]);
    chk("bp_ready_after2", {63'd0, trace_ready}, 64'd0);
    trace_pkt = '{src_id: 2'b00, mcode: NEXUS_MCODE_DIRECT_BRANCH, addr: bp_addr[2]};
    trace_v   = 1'b1;
    tick(); tick();
    chk("bp_ready_held", {63'd0, trace_ready}, 64'd0);
    chk_event("bp_head_stable", 1'b0, bp_addr[0], bp_addr[0]);
    evt_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      logic acc;
      acc = trace_v && trace_ready;
      if (evt_v) got.push_back({evt_kind, evt_addr, evt_anchor});
      tick();
      if (acc) trace_v = 1'b0;
    end
    chk("bp_trace_v_taken", {63'd0, trace_v}, 64'd0);
    trace_v = 1'b0;
    chk("bp_evt_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size())
        chk($sformatf("bp_evt%0d", i), {31'd0, got[i]}, {31'd0, 1'b0, bp_addr[i], bp_addr[i]});
    end
    chk("bp_full_cnt", {60'd0, full_cnt}, 64'd4);

    // Source filter and counter saturation
    for (int i = 0; i < 20; i++) begin
      send(2'b01, NEXUS_MCODE_DIRECT_BRANCH, 32'h5000 + 32'(i));
      chk("src_no_evt", {63'd0, evt_v}, 64'd0);
    end
    chk("src_drop_sat", {60'd0, drop_cnt}, 64'd15);
    chk("src_full_unchanged", {60'd0, full_cnt}, 64'd4);

    // Reset with two buffered events
    evt_ready = 1'b0;
    send(2'b00, NEXUS_MCODE_DIRECT_BRANCH, 32'h6000);
    send(2'b00, NEXUS_MCODE_DIRECT_BRANCH, 32'h7000);
    chk("mrst_pre_full", {62'd0, evt_v, trace_ready}, 64'b10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_evt_v", {63'd0, evt_v}, 64'd0);
    chk("mrst_cnts", {48'd0, full_cnt, comp_cnt, drop_cnt, err_cnt}, 64'd0);
    chk("mrst_synced", {63'd0, synced}, 64'd0);
    chk("mrst_ready", {63'd0, trace_ready}, 64'd1);
    evt_ready = 1'b1;
    tick();
    chk("mrst_no_stale", {63'd0, evt_v}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
